// File: rtl/chan_msg_arbiter_pkg.sv
// Shared definitions for the channel message arbiter: inter-CPU message codes,
// bus width constants and arbiter state encodings.
`default_nettype none

package chan_msg_arbiter_pkg;

    localparam int ADDR_SIZE0    = 31;
    localparam int DATA_SIZE0    = 31;
    localparam int CPU_MSG_SIZE0 = 7;

    localparam logic [CPU_MSG_SIZE0:0] CPU_R_CHAN_SET  = 8'h21;
    localparam logic [CPU_MSG_SIZE0:0] CPU_R_CHAN_DONE = 8'h22;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_DRIVE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/chan_msg_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req_i scanning upward
// from last_i+1, wrapping modulo N.
`default_nettype none

module chan_msg_arbiter_rr_pick #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] req_i,
    input  logic [2:0]   last_i,
    output logic         any_o,
    output logic [2:0]   idx_o
);

    logic [7:0] req_ext;
    logic [2:0] cand;

    // Scan from lowest priority to highest so the nearest candidate wins.
    always_comb begin
        any_o   = 1'b0;
        idx_o   = '0;
        cand    = '0;
        req_ext = 8'(req_i);
        for (int k = int'(N); k >= 1; k--) begin
            cand = 3'((int'(last_i) + k) % int'(N));
            if (req_ext[cand]) begin
                any_o = 1'b1;
                idx_o = cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/chan_msg_arbiter.sv
// Round-robin arbiter sharing one dispatcher message bus among N_REQ requesters.
// Optional ack timeout enabled by defining CHAN_ARB_TIMEOUT_EN.
`default_nettype none

module chan_msg_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MSG_W       = 8,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*MSG_W-1:0]  req_msg,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_done,
    output logic [N_REQ-1:0]        req_err,
    output logic [DATA_W-1:0]       req_resp,
    input  logic                    bus_busy,
    output logic [MSG_W-1:0]        msg_out,
    output logic [ADDR_W-1:0]       addr_out,
    output logic [DATA_W-1:0]       data_out,
    output logic                    msg_strb,
    input  logic [MSG_W-1:0]        msg_in,
    input  logic [ADDR_W-1:0]       addr_in,
    input  logic [DATA_W-1:0]       data_in,
    output logic [2:0]              grant_id
);

    import chan_msg_arbiter_pkg::*;

    arb_state_e        state_q, state_d;
    logic [2:0]        last_q, last_d, grant_q, grant_d;
    logic [MSG_W-1:0]  msg_q, msg_d, msg_out_q, msg_out_d;
    logic [ADDR_W-1:0] addr_q, addr_d, addr_out_q, addr_out_d;
    logic [DATA_W-1:0] data_q, data_d, data_out_q, data_out_d;
    logic [DATA_W-1:0] resp_q, resp_d;
    logic [N_REQ-1:0]  done_q, done_d, err_q, err_d;
    logic              strb_q, strb_d;

    logic              pick_any;
    logic [2:0]        pick_idx;
    logic [MSG_W-1:0]  sel_msg;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              ack;
    logic              tmo_expire;

    chan_msg_arbiter_rr_pick #(.N(N_REQ)) u_pick (
        .req_i  (req_valid),
        .last_i (last_q),
        .any_o  (pick_any),
        .idx_o  (pick_idx)
    );

    always_comb begin
        sel_msg  = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (pick_idx == 3'(i)) begin
                sel_msg  = req_msg[i*MSG_W +: MSG_W];
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign ack = (msg_in == MSG_W'(CPU_R_CHAN_DONE)) ||
                 ((msg_in == MSG_W'(CPU_R_CHAN_SET)) && (addr_in == addr_q));

`ifdef CHAN_ARB_TIMEOUT_EN
    logic [15:0] tmo_q;

    // Held at zero outside WAIT, so it starts from zero on every WAIT entry.
    always_ff @(posedge clk) begin
        if (rst || state_q != ARB_WAIT) tmo_q <= '0;
        else                            tmo_q <= tmo_q + 16'd1;
    end

    assign tmo_expire = (state_q == ARB_WAIT) && (tmo_q == 16'(TIMEOUT_CYC - 1));
`else
    assign tmo_expire = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        grant_d    = grant_q;
        msg_d      = msg_q;
        addr_d     = addr_q;
        data_d     = data_q;
        resp_d     = resp_q;
        done_d     = '0;
        err_d      = '0;
        strb_d     = 1'b0;
        msg_out_d  = '0;
        addr_out_d = '0;
        data_out_d = '0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any && !bus_busy) begin
                    state_d = ARB_DRIVE;
                    grant_d = pick_idx;
                    msg_d   = sel_msg;
                    addr_d  = sel_addr;
                    data_d  = sel_data;
                end
            end
            ARB_DRIVE: begin
                strb_d     = 1'b1;
                msg_out_d  = msg_q;
                addr_out_d = addr_q;
                data_out_d = data_q;
                state_d    = ARB_WAIT;
            end
            ARB_WAIT: begin
                // An ack on the expiry cycle takes precedence over the timeout.
                if (ack) begin
                    done_d  = N_REQ'(1) << grant_q;
                    resp_d  = data_in;
                    last_d  = grant_q;
                    state_d = ARB_IDLE;
                end else if (tmo_expire) begin
                    err_d   = N_REQ'(1) << grant_q;
                    last_d  = grant_q;
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            last_q     <= 3'(N_REQ - 1);
            grant_q    <= '0;
            msg_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            resp_q     <= '0;
            done_q     <= '0;
            err_q      <= '0;
            strb_q     <= 1'b0;
            msg_out_q  <= '0;
            addr_out_q <= '0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            msg_q      <= msg_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            resp_q     <= resp_d;
            done_q     <= done_d;
            err_q      <= err_d;
            strb_q     <= strb_d;
            msg_out_q  <= msg_out_d;
            addr_out_q <= addr_out_d;
            data_out_q <= data_out_d;
        end
    end

    assign req_done = done_q;
    assign req_err  = err_q;
    assign req_resp = resp_q;
    assign msg_out  = msg_out_q;
    assign addr_out = addr_out_q;
    assign data_out = data_out_q;
    assign msg_strb = strb_q;
    assign grant_id = grant_q;

endmodule

`default_nettype wire

// File: tb/tb_chan_msg_arbiter.sv
// Directed self-checking bench for chan_msg_arbiter (4 requesters, 32-bit bus).
`default_nettype none

module tb_chan_msg_arbiter;

    import chan_msg_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*MW-1:0] req_msg;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_done;
    logic [N-1:0]    req_err;
    logic [DW-1:0]   req_resp;
    logic            bus_busy;
    logic [MW-1:0]   msg_out;
    logic [AW-1:0]   addr_out;
    logic [DW-1:0]   data_out;
    logic            msg_strb;
    logic [MW-1:0]   msg_in;
    logic [AW-1:0]   addr_in;
    logic [DW-1:0]   data_in;
    logic [2:0]      grant_id;

    int n_checks = 0;
    int n_errors = 0;

    chan_msg_arbiter #(
        .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MSG_W(MW), .TIMEOUT_CYC(8)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_msg(req_msg), .req_addr(req_addr), .req_data(req_data),
        .req_done(req_done), .req_err(req_err), .req_resp(req_resp),
        .bus_busy(bus_busy),
        .msg_out(msg_out), .addr_out(addr_out), .data_out(data_out), .msg_strb(msg_strb),
        .msg_in(msg_in), .addr_in(addr_in), .data_in(data_in),
        .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [MW-1:0] m,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_msg[idx*MW +: MW]  = m;
        req_addr[idx*AW +: AW] = a;
        req_data[idx*DW +: DW] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    logic seen;

    initial begin
        rst = 1'b1; req_valid = '0; req_msg = '0; req_addr = '0; req_data = '0;
        bus_busy = 1'b0; msg_in = '0; addr_in = '0; data_in = '0;
        step(); step();
        rst = 1'b0;

        // Reset state
        check("rst_strb",  64'(msg_strb), 64'd0);
        check("rst_done",  64'(req_done), 64'd0);
        check("rst_err",   64'(req_err),  64'd0);
        check("rst_grant", 64'(grant_id), 64'd0);
        check("rst_resp",  64'(req_resp), 64'd0);
        check("rst_addr",  64'(addr_out), 64'd0);

        // Single request on requester 1
        set_req(1, CPU_R_CHAN_SET, 32'h40, 32'h1234);
        req_valid = 4'b0010;
        step();
        check("single_strb_early", 64'(msg_strb), 64'd0);
        check("single_grant",      64'(grant_id), 64'd1);
        step();
        check("single_strb", 64'(msg_strb), 64'd1);
        check("single_msg",  64'(msg_out),  64'h21);
        check("single_addr", 64'(addr_out), 64'h40);
        check("single_data", 64'(data_out), 64'h1234);
        msg_in = CPU_R_CHAN_SET; addr_in = 32'h40; data_in = 32'hBEEF;
        step();
        check("single_done",     64'(req_done), 64'b0010);
        check("single_resp",     64'(req_resp), 64'hBEEF);
        check("single_strb_off", 64'(msg_strb), 64'd0);
        check("single_addr_off", 64'(addr_out), 64'd0);
        msg_in = '0; addr_in = '0; data_in = '0; req_valid = '0;
        step();
        check("single_done_off", 64'(req_done), 64'd0);

        // Fairness with all requesters valid, immediate acks
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, CPU_R_CHAN_SET, 32'h100 + 32'(i), 32'(i));
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            check("fair_grant", 64'(grant_id), 64'(k % N));
            step();
            check("fair_strb", 64'(msg_strb), 64'd1);
            msg_in = CPU_R_CHAN_DONE;
            step();
            check("fair_done", 64'(req_done), 64'(4'b0001 << (k % N)));
            msg_in = '0;
        end
        req_valid = '0;

        // Ack presented during DRIVE is ignored
        do_reset();
        set_req(3, CPU_R_CHAN_SET, 32'h80, 32'h55);
        req_valid = 4'b1000;
        step();
        check("drvack_grant", 64'(grant_id), 64'd3);
        msg_in = CPU_R_CHAN_DONE;
        step();
        msg_in = '0;
        check("drvack_strb", 64'(msg_strb), 64'd1);
        step();
        check("drvack_no_done", 64'(req_done), 64'd0);
        msg_in = CPU_R_CHAN_DONE;
        step();
        check("drvack_done", 64'(req_done), 64'b1000);
        msg_in = '0; req_valid = '0;

        // Bus busy holds off the grant
        do_reset();
        set_req(0, CPU_R_CHAN_SET, 32'h10, 32'h77);
        req_valid = 4'b0001; bus_busy = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            seen = seen | msg_strb;
        end
        check("busy_no_strb", 64'(seen), 64'd0);
        bus_busy = 1'b0;
        step();
        check("busy_strb_wait", 64'(msg_strb), 64'd0);
        step();
        check("busy_strb", 64'(msg_strb), 64'd1);
        check("busy_addr", 64'(addr_out), 64'h10);
        msg_in = CPU_R_CHAN_DONE;
        step();
        check("busy_done", 64'(req_done), 64'b0001);
        msg_in = '0; req_valid = '0;

        // Mismatched ack address keeps WAIT; a later CHAN_DONE completes
        do_reset();
        set_req(0, CPU_R_CHAN_SET, 32'h40, 32'h99);
        req_valid = 4'b0001;
        step(); step();
        msg_in = CPU_R_CHAN_SET; addr_in = 32'h44;
        seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            seen = seen | (|req_done);
        end
        check("mis_no_done", 64'(seen), 64'd0);
        check("mis_strb_off", 64'(msg_strb), 64'd0);
        msg_in = CPU_R_CHAN_DONE; addr_in = '0; data_in = 32'hCAFE;
        step();
        check("mis_done", 64'(req_done), 64'b0001);
        check("mis_resp", 64'(req_resp), 64'hCAFE);
        msg_in = '0; data_in = '0; req_valid = '0;
        step();

        // Reset in WAIT aborts; next grant goes to requester 0
        set_req(2, CPU_R_CHAN_SET, 32'h60, 32'h66);
        req_valid = 4'b0100;
        step();
        check("rwait_grant", 64'(grant_id), 64'd2);
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rwait_done", 64'(req_done), 64'd0);
        check("rwait_err",  64'(req_err),  64'd0);
        check("rwait_strb", 64'(msg_strb), 64'd0);
        check("rwait_msg",  64'(msg_out),  64'd0);
        req_valid = 4'b0101;
        step();
        check("rwait_regrant", 64'(grant_id), 64'd0);
        req_valid = '0;
        do_reset();

`ifdef CHAN_ARB_TIMEOUT_EN
        // Timeout after 8 WAIT cycles, then next requester; ack on expiry wins
        set_req(0, CPU_R_CHAN_SET, 32'h200, 32'h1);
        set_req(1, CPU_R_CHAN_SET, 32'h204, 32'h2);
        req_valid = 4'b0011;
        step(); step();
        seen = 1'b0;
        for (int c = 0; c < 7; c++) begin
            step();
            seen = seen | (|req_err);
        end
        check("tmo_no_early_err", 64'(seen), 64'd0);
        step();
        check("tmo_err",     64'(req_err),  64'b0001);
        check("tmo_no_done", 64'(req_done), 64'd0);
        step();
        check("tmo_next_grant", 64'(grant_id), 64'd1);
        step();
        for (int c = 0; c < 7; c++) step();
        msg_in = CPU_R_CHAN_DONE;
        step();
        check("tmo_ack_done", 64'(req_done), 64'b0010);
        check("tmo_ack_err",  64'(req_err),  64'd0);
        msg_in = '0; req_valid = '0;
        step();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/chan_msg_arbiter.md
Name: chan_msg_arbiter

Overview:
- Shares one dispatcher message bus (msg code / addr / data / strobe) between N channel-controller requesters. Each requester otherwise drives CHAN_SET messages to the dispatcher by itself.
- Round-robin grant, one outstanding transaction at a time, completion via dispatcher acknowledge.
- Sits between the per-core channel controllers and the dispatcher; the rest of the design sees a single requester.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- ADDR_W, 32, address width (matches ADDR_SIZE0+1)
- DATA_W, 32, data width (matches DATA_SIZE0+1)
- MSG_W, 8, message code width (matches CPU_MSG_SIZE0+1)
- TIMEOUT_CYC, 255, ack timeout in cycles (used only with the optional feature)

Ports:
- clk  in  1  single clock, all logic on its rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  N_REQ  per-requester request; held with payload stable until req_done or req_err
- req_msg  in  N_REQ*MSG_W  packed message codes, requester i at [i*MSG_W +: MSG_W]
- req_addr  in  N_REQ*ADDR_W  packed channel addresses
- req_data  in  N_REQ*DATA_W  packed payloads
- req_done  out  N_REQ  one-cycle completion pulse to the granted requester
- req_err  out  N_REQ  one-cycle timeout pulse; tied 0 without the optional feature
- req_resp  out  DATA_W  dispatcher response data; valid while req_done is high
- bus_busy  in  1  dispatcher bus occupied by another agent
- msg_out  out  MSG_W  message code to dispatcher
- addr_out  out  ADDR_W  address to dispatcher
- data_out  out  DATA_W  data to dispatcher
- msg_strb  out  1  one-cycle strobe marking msg_out/addr_out/data_out valid
- msg_in  in  MSG_W  dispatcher reply code
- addr_in  in  ADDR_W  dispatcher reply address
- data_in  in  DATA_W  dispatcher reply data
- grant_id  out  3  index of the current or last granted requester

Behaviour:
- Reset: state IDLE. All outputs 0. Latched payload 0. Round-robin pointer last = N_REQ-1, so requester 0 has first priority.
- Registered outputs: msg_out, addr_out and data_out are nonzero only in the DRIVE cycle and read 0 otherwise, so they can be OR-combined with other bus agents.
- State machine:
  - IDLE:
    - If any req_valid and bus_busy=0: pick the first valid index scanning last+1, last+2, ... modulo N_REQ. Latch its msg/addr/data, set grant_id, go to DRIVE.
    - If bus_busy=1: stay in IDLE. No grant is taken and requests wait.
  - DRIVE (exactly 1 cycle): drive the latched payload and msg_strb=1, then go to WAIT.
  - WAIT: wait for an ack cycle, defined as msg_in == CPU_R_CHAN_DONE, or msg_in == CPU_R_CHAN_SET with addr_in == latched addr. On the ack cycle (next edge):
    - pulse req_done[grant_id];
    - set req_resp = data_in;
    - set last = grant_id;
    - return to IDLE.
- Latency: a request sampled at edge t with the bus free gives msg_strb high after edge t+1. The earliest req_done follows the ack edge. Minimum turnaround back to IDLE is 3 cycles.
- Requester protocol: requester i must not deassert req_valid[i] before req_done[i] or req_err[i]. If it drops early, the arbiter still completes the transaction and the done pulse is discarded by the requester.
- Simultaneous events:
  - An ack in the same cycle as new requests is handled first. The new grant occurs in IDLE on the following cycle.
  - An ack seen during DRIVE is ignored.
- Fairness: with all requesters continuously valid, grants cycle 0,1,2,3,0,...
- Reset mid-operation: a synchronous rst in any state aborts the transaction immediately. No done or err pulse is generated, and strobe and outputs are forced to 0 on that edge.
- Widths: grant_id is zero-extended. Packed-vector slicing uses grant_id; grant_id ≥ N_REQ is unreachable.

Optional Feature:
- Macro: CHAN_ARB_TIMEOUT_EN.
- When defined:
  - an 8..16-bit counter clears on entry to WAIT and increments each WAIT cycle;
  - if it reaches TIMEOUT_CYC with no ack, pulse req_err[grant_id], set last = grant_id and return to IDLE;
  - an ack on the same cycle as expiry wins and produces req_done.
- When undefined: no counter, WAIT persists until ack, and req_err is constant 0.

Decomposition:
- Shared package / include headers:
  - message codes CPU_R_CHAN_SET and CPU_R_CHAN_DONE (existing inter-CPU message header);
  - arbiter state encodings IDLE/DRIVE/WAIT as constants alongside the existing state header;
  - width macros ADDR_SIZE0, DATA_SIZE0, CPU_MSG_SIZE0.
- Sub-module: rr_pick, a combinational round-robin priority picker.
  - Inputs: req vector, last pointer.
  - Outputs: any, idx.
  - Reused by future schedulers.

Test Plan:
- Single request: req_valid=4'b0010, msg=CPU_R_CHAN_SET, addr=0x40, data=0x1234 → msg_strb one cycle later with addr_out=0x40, data_out=0x1234. Ack with msg_in=CHAN_SET, addr_in=0x40, data_in=0xBEEF → req_done=4'b0010 and req_resp=0xBEEF the next cycle.
- Fairness: req_valid=4'b1111 held, immediate ack each time → grant_id sequence 0,1,2,3,0. No requester is starved.
- Bus busy: bus_busy=1 for 10 cycles with req_valid=4'b0001 → no msg_strb during the 10 cycles; strobe appears 1 cycle after bus_busy falls.
- Mismatched ack: msg_in=CHAN_SET with addr_in=0x44 while latched addr=0x40 → stays in WAIT with no done. A later CPU_R_CHAN_DONE → done.
- Reset mid-WAIT: rst pulsed for 1 cycle while in WAIT → all outputs 0, no done or err. The next grant goes to requester 0 if it is valid.
- Timeout (CHAN_ARB_TIMEOUT_EN, TIMEOUT_CYC=8): no ack → req_err pulse 8 cycles after entering WAIT, and the next requester is granted. Ack on the expiry cycle → req_done, no err.
